// File: rtl/burst_writer.sv
// Periodic sample generator feeding a small FIFO, drained in fixed-length
// request bursts towards an arbiter; samples arriving on a full FIFO are counted as drops.
module burst_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int PERIOD     = 5,
  parameter int BURST_LEN  = 4,
  parameter int DEPTH      = 8,
  parameter int DROP_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_busy,
  output logic                     o_req,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_last,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [DROP_WIDTH-1:0]    o_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);
  localparam logic [BW-1:0] BEAT_LAST   = BW'(BURST_LEN - 1);
  localparam logic [AW:0]   LEVEL_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_BURST = (AW + 1)'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                  state;
  logic [PW-1:0]           period_cnt;
  logic [DATA_WIDTH-1:0]   seq;
  logic [BW-1:0]           beat;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    sample;
  logic                    push;
  logic                    pop;

  // Fullness is judged on the pre-pop level, so push-on-full with a pop still drops.
  assign sample = i_enable && (period_cnt == PERIOD_LAST);
  assign push   = sample && (o_level != LEVEL_FULL);
  assign pop    = (state == BURST) && !i_busy;
  assign o_data = mem[rd_ptr];

  // Sample generator: period counter and sequence register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      period_cnt <= '0;
      seq        <= '0;
    end else if (!i_enable) begin
      period_cnt <= '0;
    end else if (sample) begin
      period_cnt <= '0;
      seq        <= seq + DATA_WIDTH'(1);
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= seq;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_level      <= '0;
      o_drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   o_level <= o_level + (AW + 1)'(1);
        2'b01:   o_level <= o_level - (AW + 1)'(1);
        default: o_level <= o_level;
      endcase
      if (sample && !push && (o_drop_count != '1)) begin
        o_drop_count <= o_drop_count + DROP_WIDTH'(1);
      end
    end
  end

  // Burst controller with registered request, last flag and beat counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      o_req  <= 1'b0;
      o_last <= 1'b0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (o_level >= LEVEL_BURST) begin
            state  <= BURST;
            o_req  <= 1'b1;
            o_last <= (BURST_LEN == 1);
            beat   <= '0;
          end
        end
        BURST: begin
          if (!i_busy) begin
            if (beat == BEAT_LAST) begin
              state  <= GAP;
              o_req  <= 1'b0;
              o_last <= 1'b0;
              beat   <= '0;
            end else begin
              beat   <= beat + BW'(1);
              o_last <= ((beat + BW'(1)) == BEAT_LAST);
            end
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          o_req  <= 1'b0;
          o_last <= 1'b0;
          beat   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_writer.sv
// Directed bench for burst_writer: a reference model queues expected words
// as samples are generated and checks them as the DUT transfers them.
module tb_burst_writer;

  localparam int DW     = 8;
  localparam int PERIOD = 5;
  localparam int BL     = 4;
  localparam int DEPTH  = 8;
  localparam int DRW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          busy;
  logic          req;
  logic [DW-1:0] data;
  logic          last;
  logic [3:0]    level;
  logic [DRW-1:0] drops;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  int m_pcnt;
  int m_seq;
  int m_drops;
  int m_beat;

  burst_writer #(
    .DATA_WIDTH(DW), .PERIOD(PERIOD), .BURST_LEN(BL), .DEPTH(DEPTH), .DROP_WIDTH(DRW)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_busy(busy),
    .o_req(req), .o_data(data), .o_last(last), .o_level(level), .o_drop_count(drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pcnt  = 0;
    m_seq   = 0;
    m_drops = 0;
    m_beat  = 0;
  endtask

  // One clock: score any transfer, advance the model, then check occupancy at the negedge.
  task automatic tick();
    logic xfer, gen, full;
    xfer = (req === 1'b1) && !busy;
    gen  = en && (m_pcnt == PERIOD - 1);
    full = (exp_q.size() == DEPTH);
    if (req !== 1'b1) chk("last_without_req", last, 0);
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("req_on_empty", req, 0);
      end else begin
        chk("data", data, exp_q[0]);
        chk("last", last, (m_beat == BL - 1));
        void'(exp_q.pop_front());
        m_beat = (m_beat == BL - 1) ? 0 : m_beat + 1;
      end
    end
    if (gen) begin
      if (!full) exp_q.push_back(m_seq[DW-1:0]);
      else if (m_drops < 255) m_drops++;
      m_seq = (m_seq + 1) % 256;
    end
    m_pcnt = (!en || gen) ? 0 : m_pcnt + 1;
    @(posedge clk);
    @(negedge clk);
    chk("level", level, exp_q.size());
    chk("drops", drops, m_drops);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_req", req, 0);
    chk("rst_last", last, 0);
    chk("rst_level", level, 0);
    chk("rst_drops", drops, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    busy = 1'b0;
    model_reset();

    // Basic burst: four samples then four back-to-back beats
    do_reset();
    en = 1'b1;
    repeat (4) tick();
    chk("t1_level_before_first", level, 0);
    tick();
    chk("t1_level_first", level, 1);
    repeat (15) tick();
    chk("t1_level4", level, 4);
    chk("t1_req_low", req, 0);
    tick();
    chk("t1_req_rise", req, 1);
    chk("t1_d0", data, 0);
    chk("t1_last0", last, 0);
    tick(); chk("t1_d1", data, 1);
    tick(); chk("t1_d2", data, 2);
    tick(); chk("t1_d3", data, 3); chk("t1_last3", last, 1);
    tick(); chk("t1_gap", req, 0);
    tick(); chk("t1_idle", req, 0);

    // Busy hold for ten cycles with the first word presented
    do_reset();
    en = 1'b1;
    repeat (21) tick();
    chk("t2_req", req, 1);
    chk("t2_d0", data, 0);
    busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_hold_req", req, 1);
      chk("t2_hold_data", data, 0);
      chk("t2_hold_last", last, 0);
    end
    busy = 1'b0;
    tick(); chk("t2_d1", data, 1);
    tick(); chk("t2_d2", data, 2);
    tick(); chk("t2_d3", data, 3); chk("t2_last", last, 1);
    tick(); chk("t2_gap", req, 0);

    // Permanent busy: FIFO fills, drops accumulate and saturate
    do_reset();
    en   = 1'b1;
    busy = 1'b1;
    repeat (40) tick();
    chk("t3_full", level, 8);
    chk("t3_no_drop", drops, 0);
    repeat (5) tick();
    chk("t3_drop1", drops, 1);
    repeat (5) tick();
    chk("t3_drop2", drops, 2);
    repeat (255 * 5) tick();
    chk("t3_drop_sat", drops, 255);
    chk("t3_still_full", level, 8);
    chk("t3_req_held", req, 1);
    busy = 1'b0;

    // Asynchronous reset between edges during beat 2
    do_reset();
    en = 1'b1;
    repeat (21) tick();
    tick();
    tick();
    chk("t4_beat2", data, 2);
    #1 rst = 1'b1;
    #1;
    chk("t4_async_req", req, 0);
    chk("t4_async_level", level, 0);
    chk("t4_async_last", last, 0);
    model_reset();
    #1 rst = 1'b0;
    repeat (21) tick();
    chk("t4_restart_req", req, 1);
    chk("t4_restart_d0", data, 0);
    tick(); chk("t4_restart_d1", data, 1);

    // Enable dropped for three cycles mid-period restarts the period count
    do_reset();
    en = 1'b1;
    repeat (7) tick();
    chk("t5_level1", level, 1);
    en = 1'b0;
    repeat (3) tick();
    chk("t5_paused", level, 1);
    en = 1'b1;
    repeat (4) tick();
    chk("t5_not_yet", level, 1);
    tick();
    chk("t5_sample", level, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
